// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: imem request/response channel and the
// {instr, pc} valid/ready channel toward decode.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        output instr_valid,
        output instr,
        output instr_pc,
        input  instr_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        input  instr_valid,
        input  instr,
        input  instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Fetch front end: PC, imem request credits, prefetch FIFO, redirects.
// Define MISALIGN_TRAP_EN to halt on a misaligned redirect target.
module fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus,
    input  logic [1:0]    pcsrc,
    input  logic [31:0]   redirect_pc,
    input  logic [31:0]   imm_ext,
    input  logic [31:0]   alu_result,
    output logic          fetch_misalign
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [31:0]   raw_target;
    logic [31:0]   target;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] out_next;
    logic [OW-1:0] drop_cnt;
    logic [CW-1:0] count;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [31:0]   data_q [FIFO_DEPTH];
    logic [31:0]   pc_q   [FIFO_DEPTH];
    logic          redirect_req;
    logic          redirect;
    logic          halted;
    logic          accept;
    logic          drop;
    logic          push;
    logic          pop;

    assign redirect_req = (pcsrc == 2'b01) || (pcsrc == 2'b10);
    assign raw_target   = (pcsrc == 2'b10) ? {alu_result[31:1], 1'b0}
                                           : redirect_pc + imm_ext;

`ifdef MISALIGN_TRAP_EN
    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HALT = 1'b1;

    logic [0:0] state;
    logic       trap;

    assign redirect = redirect_req && !halted;
    assign target   = raw_target;
    assign trap     = redirect && (raw_target[1:0] != 2'b00);
    assign halted   = (state == HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= RUN;
            fetch_misalign <= 1'b0;
        end else if (trap) begin
            state          <= HALT;
            fetch_misalign <= 1'b1;
        end
    end
`else
    assign redirect       = redirect_req;
    assign target         = raw_target & ~32'h3;
    assign halted         = 1'b0;
    assign fetch_misalign = 1'b0;
`endif

    // Credits cover both in-flight requests and buffered words.
    assign bus.imem_req_valid = rst_n && !redirect && !halted
        && (32'(outstanding) < MAX_OUTSTANDING)
        && (32'(outstanding) + 32'(count) < FIFO_DEPTH);
    assign bus.imem_req_addr  = fetch_pc;

    assign accept   = bus.imem_req_valid && bus.imem_req_ready;
    assign drop     = (drop_cnt != '0);
    assign push     = bus.imem_rsp_valid && !drop && !redirect && !halted;
    assign pop      = bus.instr_valid && bus.instr_ready && !redirect;
    assign out_next = outstanding + OW'(accept) - OW'(bus.imem_rsp_valid);

    assign bus.instr_valid = (count != '0);
    assign bus.instr       = data_q[rptr];
    assign bus.instr_pc    = pc_q[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            count       <= '0;
            wptr        <= '0;
            rptr        <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            outstanding <= out_next;
            if (redirect) begin
                // Everything still in flight belongs to the old path.
                fetch_pc <= target;
                rsp_pc   <= target;
                drop_cnt <= out_next;
                count    <= '0;
                wptr     <= '0;
                rptr     <= '0;
            end else begin
                if (accept)
                    fetch_pc <= fetch_pc + 32'd4;
                if (bus.imem_rsp_valid && drop)
                    drop_cnt <= drop_cnt - 1'b1;
                if (push) begin
                    data_q[wptr] <= bus.imem_rsp_data;
                    pc_q[wptr]   <= rsp_pc;
                    wptr         <= wptr + 1'b1;
                    rsp_pc       <= rsp_pc + 32'd4;
                end
                if (pop)
                    rptr <= rptr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && count == CW'(FIFO_DEPTH)));
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: latency-programmable imem model,
// redirect vector table and hand-written reset/backpressure sequences.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  pcsrc = 2'b00;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imm_ext = '0;
    logic [31:0] alu_result = '0;
    logic        fetch_misalign;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .pcsrc          (pcsrc),
        .redirect_pc    (redirect_pc),
        .imm_ext        (imm_ext),
        .alu_result     (alu_result),
        .fetch_misalign (fetch_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          lat;
        logic [1:0]  src;
        logic        rdy;
        logic        seq;
        logic [31:0] rpc;
        logic [31:0] imm;
        logic [31:0] alu;
        logic [31:0] target;
    } rec_t;

    rec_t        tbl[$];
    int          lat = 1;
    int          cyc = 0;
    int          due_q[$];
    logic [31:0] dat_q[$];
    int          passed = 0;
    int          total = 0;
    logic [31:0] exp_pc = '0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // In-order memory: response visible lat cycles after accept.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            due_q.delete();
            dat_q.delete();
            cyc = 0;
            bus.imem_rsp_valid <= 1'b0;
            bus.imem_rsp_data  <= '0;
        end else begin
            cyc = cyc + 1;
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                due_q.push_back(cyc + lat - 1);
                dat_q.push_back(memf(bus.imem_req_addr));
            end
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                bus.imem_rsp_valid <= 1'b1;
                bus.imem_rsp_data  <= dat_q.pop_front();
                void'(due_q.pop_front());
            end else begin
                bus.imem_rsp_valid <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic consume(input int n, input string tag, output int gaps);
        int w;
        gaps = 0;
        for (int k = 0; k < n; k++) begin
            w = 0;
            @(negedge clk);
            while (!bus.instr_valid && w < 20) begin
                w++;
                gaps++;
                @(negedge clk);
            end
            if (!bus.instr_valid) begin
                total++;
                $display("FAIL %s timeout: instr_valid 0, expected 1", tag);
                return;
            end
            check({tag, " pc"}, bus.instr_pc, exp_pc);
            check({tag, " instr"}, bus.instr, memf(exp_pc));
            exp_pc += 32'd4;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int g;
        int w;
        logic any_req;
        logic any_vld;

        tbl.push_back('{"branch back", 2, 2'b01, 1'b1, 1'b0,
                        32'h10, 32'hFFFF_FFF8, 32'h0, 32'h8});
        tbl.push_back('{"jalr odd", 1, 2'b10, 1'b1, 1'b0,
                        32'h0, 32'h0, 32'h105, 32'h104});
        tbl.push_back('{"wrap", 1, 2'b01, 1'b1, 1'b0,
                        32'h0, 32'hFFFF_FFF8, 32'h0, 32'hFFFF_FFF8});
        tbl.push_back('{"reserved", 2, 2'b11, 1'b0, 1'b1,
                        32'h40, 32'h40, 32'h40, 32'h0});
        tbl.push_back('{"jal fwd", 2, 2'b01, 1'b1, 1'b0,
                        32'h1000, 32'h234, 32'h0, 32'h1234});
`ifndef MISALIGN_TRAP_EN
        tbl.push_back('{"br misal", 1, 2'b01, 1'b1, 1'b0,
                        32'h200, 32'h22, 32'h0, 32'h220});
        tbl.push_back('{"jalr misal", 2, 2'b10, 1'b1, 1'b0,
                        32'h0, 32'h0, 32'h1003, 32'h1000});
`endif

        bus.imem_req_ready = 1'b1;
        bus.instr_ready    = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("rst req_addr", bus.imem_req_addr, 32'h0);
        check("rst instr_valid", 32'(bus.instr_valid), 32'd0);
        check("rst instr", bus.instr, 32'h0);
        check("rst instr_pc", bus.instr_pc, 32'h0);
        check("rst misalign", 32'(fetch_misalign), 32'd0);

        rst_n = 1'b1;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!bus.instr_valid && w < 20);
        check("first latency", 32'(w), 32'd2);
        exp_pc = 32'h0;
        check("first pc", bus.instr_pc, exp_pc);
        check("first instr", bus.instr, memf(exp_pc));
        exp_pc += 32'd4;
        @(posedge clk);
        #1;
        consume(7, "stream", g);
        check("stream gaps", 32'(g), 32'd0);

        bus.instr_ready = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("stall req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("stall instr_valid", 32'(bus.instr_valid), 32'd1);
        check("stall head pc", bus.instr_pc, exp_pc);
        check("stall fetch addr", bus.imem_req_addr, exp_pc + 32'd16);
        @(posedge clk);
        #1;
        bus.instr_ready = 1'b1;
        consume(8, "drain", g);

        foreach (tbl[i]) begin
            lat = tbl[i].lat;
            consume(4, {tbl[i].name, " pre"}, g);
            redirect_pc     = tbl[i].rpc;
            imm_ext         = tbl[i].imm;
            alu_result      = tbl[i].alu;
            pcsrc           = tbl[i].src;
            bus.instr_ready = tbl[i].rdy;
            @(posedge clk);
            #1;
            pcsrc           = 2'b00;
            bus.instr_ready = 1'b1;
            if (!tbl[i].seq) exp_pc = tbl[i].target;
            consume(3, tbl[i].name, g);
        end

        lat = 2;
        consume(2, "pre rst", g);
        rst_n = 1'b0;
        #1;
        check("midrst req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("midrst req_addr", bus.imem_req_addr, 32'h0);
        check("midrst instr_valid", 32'(bus.instr_valid), 32'd0);
        check("midrst instr", bus.instr, 32'h0);
        check("midrst instr_pc", bus.instr_pc, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        lat = 1;
        exp_pc = 32'h0;
        consume(3, "restart", g);

`ifndef MISALIGN_TRAP_EN
        check("no trap", 32'(fetch_misalign), 32'd0);
`else
        alu_result = 32'h106;
        pcsrc      = 2'b10;
        @(posedge clk);
        #1;
        pcsrc   = 2'b00;
        any_req = 1'b0;
        any_vld = 1'b0;
        repeat (6) begin
            @(negedge clk);
            any_req |= bus.imem_req_valid;
            any_vld |= bus.instr_valid;
        end
        check("trap misalign", 32'(fetch_misalign), 32'd1);
        check("trap no req", 32'(any_req), 32'd0);
        check("trap no instr", 32'(any_vld), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
